// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
package ps2_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned TOUT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_rx_state_t;

   // Returns 1 when the 9-bit word (8 data bits plus parity bit) holds an odd number of ones.
   function automatic logic odd_parity9(input logic [8:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is visible on rdata while count is non-zero.
module ps2_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_c, do_pop_c;

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   always_comb begin
      do_pop_c  = pop & (count_q != '0);
      do_push_c = push & ((count_q != CW'(DEPTH)) | do_pop_c);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (do_push_c) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop_c) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver with glitch filter, frame timeout and a receive FIFO.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter logic [15:0] OVER_TIME  = 16'd1000,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned FILTER_LEN = 4,
   parameter int unsigned PARITY_EN  = 1
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            peripheral_clock,
   input  logic                            device_clock,
   input  logic                            device_data,
   output logic                            inhibit_clock,
   output logic [7:0]                      rx_data,
   output logic                            rx_valid,
   input  logic                            rx_ready,
   output logic                            frame_error,
   output logic                            parity_error,
   output logic                            timeout_error,
   output logic                            overflow,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

   logic dclk_s1_q, dclk_s1_d, dclk_s2_q, dclk_s2_d;
   logic ddat_s1_q, ddat_s1_d, ddat_s2_q, ddat_s2_d;
   logic pclk_s1_q, pclk_s1_d, pclk_s2_q, pclk_s2_d, pclk_prev_q, pclk_prev_d;
   logic             filt_q, filt_d;
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;

   ps2_rx_state_t     state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [TOUT_W-1:0] tout_q, tout_d;
   logic frame_error_q, frame_error_d, parity_error_q, parity_error_d;
   logic timeout_error_q, timeout_error_d, overflow_q, overflow_d;
   logic inhibit_q, inhibit_d;

   logic fall_c, ptick_c, push_c, pop_c, full_c, empty_c;

   // Synchronizers and the clock-line stability filter.
   always_comb begin
      dclk_s1_d   = device_clock;
      dclk_s2_d   = dclk_s1_q;
      ddat_s1_d   = device_data;
      ddat_s2_d   = ddat_s1_q;
      pclk_s1_d   = peripheral_clock;
      pclk_s2_d   = pclk_s1_q;
      pclk_prev_d = pclk_s2_q;
      filt_d      = filt_q;
      flt_cnt_d   = '0;
      if (dclk_s2_q != filt_q) begin
         if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            filt_d = dclk_s2_q;
         end else begin
            flt_cnt_d = flt_cnt_q + FLT_W'(1);
         end
      end
   end

   assign fall_c  = filt_q & ~filt_d;
   assign ptick_c = pclk_s2_q & ~pclk_prev_q;
   assign pop_c   = ~empty_c & rx_ready;

   // Frame FSM; a timeout takes priority over any edge seen in the same cycle.
   always_comb begin
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      shift_d         = shift_q;
      par_d           = par_q;
      tout_d          = tout_q;
      push_c          = 1'b0;
      frame_error_d   = 1'b0;
      parity_error_d  = 1'b0;
      timeout_error_d = 1'b0;

      if ((state_q == ST_IDLE) || fall_c) begin
         tout_d = '0;
      end else if (ptick_c && (tout_q < OVER_TIME)) begin
         tout_d = tout_q + TOUT_W'(1);
      end

      if ((state_q != ST_IDLE) && (tout_q == OVER_TIME)) begin
         timeout_error_d = 1'b1;
         state_d         = ST_IDLE;
      end else if (fall_c) begin
         case (state_q)
            ST_IDLE: begin
               if (!ddat_s2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               shift_d   = {ddat_s2_q, shift_q[BYTE_W-1:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               par_d   = ddat_s2_q;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (!ddat_s2_q) begin
                  frame_error_d = 1'b1;
               end else if ((PARITY_EN != 0) && !odd_parity9({shift_q, par_q})) begin
                  parity_error_d = 1'b1;
               end else begin
                  push_c = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      overflow_d = push_c & full_c & ~pop_c;

      if (fifo_count < CNT_W'(FIFO_DEPTH - 1)) begin
         inhibit_d = 1'b0;
      end else if (state_q == ST_IDLE) begin
         inhibit_d = 1'b1;
      end else begin
         inhibit_d = inhibit_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dclk_s1_q       <= 1'b1;
         dclk_s2_q       <= 1'b1;
         ddat_s1_q       <= 1'b1;
         ddat_s2_q       <= 1'b1;
         pclk_s1_q       <= 1'b1;
         pclk_s2_q       <= 1'b1;
         pclk_prev_q     <= 1'b1;
         filt_q          <= 1'b1;
         flt_cnt_q       <= '0;
         state_q         <= ST_IDLE;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         par_q           <= 1'b0;
         tout_q          <= '0;
         frame_error_q   <= 1'b0;
         parity_error_q  <= 1'b0;
         timeout_error_q <= 1'b0;
         overflow_q      <= 1'b0;
         inhibit_q       <= 1'b0;
      end else begin
         dclk_s1_q       <= dclk_s1_d;
         dclk_s2_q       <= dclk_s2_d;
         ddat_s1_q       <= ddat_s1_d;
         ddat_s2_q       <= ddat_s2_d;
         pclk_s1_q       <= pclk_s1_d;
         pclk_s2_q       <= pclk_s2_d;
         pclk_prev_q     <= pclk_prev_d;
         filt_q          <= filt_d;
         flt_cnt_q       <= flt_cnt_d;
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         par_q           <= par_d;
         tout_q          <= tout_d;
         frame_error_q   <= frame_error_d;
         parity_error_q  <= parity_error_d;
         timeout_error_q <= timeout_error_d;
         overflow_q      <= overflow_d;
         inhibit_q       <= inhibit_d;
      end
   end

   ps2_sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push_c),
      .pop     (pop_c),
      .wdata   (shift_q),
      .rdata   (rx_data),
      .count   (fifo_count),
      .full    (full_c),
      .empty   (empty_c)
   );

   assign rx_valid      = ~empty_c;
   assign inhibit_clock = inhibit_q;
   assign frame_error   = frame_error_q;
   assign parity_error  = parity_error_q;
   assign timeout_error = timeout_error_q;
   assign overflow      = overflow_q;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter OVER_TIME, default 16'd1000: timeout limit in peripheral_clock rising edges.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter FILTER_LEN, default 4: stable samples needed before the filtered device_clock changes.
REQ-004 SHALL have parameter PARITY_EN, default 1: 1 = enforce odd parity, 0 = ignore parity bit.
REQ-005 SHALL have port: clock  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: peripheral_clock  in  1  slow tick source for the timeout.
REQ-008 SHALL have port: device_clock  in  1  PS/2 clock line; device_data  in  1  PS/2 data line.
REQ-009 SHALL have port: inhibit_clock  out  1  1 = request the external driver to hold PS/2 clock low.
REQ-010 SHALL have port: rx_data  out  8  FIFO head byte.
REQ-011 SHALL have ports: rx_valid  out  1  head valid; rx_ready  in  1  consumer accepts head.
REQ-012 SHALL have ports: frame_error, parity_error, timeout_error, overflow  out  1 each  single-cycle pulses.
REQ-013 SHALL have port: fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.

Function
REQ-014 SHALL pass device_clock, device_data and peripheral_clock through 2-FF synchronizers; all three reset to 1.
REQ-015 SHALL change filtered clock only after FILTER_LEN consecutive synchronized samples differ from it; reset value 1.
REQ-016 SHALL detect a falling edge as filtered clock 1->0 and sample synchronized data in that same cycle.
REQ-017 SHALL implement states IDLE, DATA, PARITY, STOP; reset state IDLE.
REQ-018 IDLE: edge with data 0 -> DATA and bit count cleared; edge with data 1 is ignored.
REQ-019 DATA: each edge shifts data in LSB first; the 8th edge -> PARITY.
REQ-020 PARITY: edge captures the parity bit -> STOP.
REQ-021 STOP: edge -> IDLE; a frame is good if stop bit = 1 and (PARITY_EN = 0, or the ones count over 8 data bits plus parity is odd).
REQ-022 Good frame SHALL push the byte at the end of the stop-edge cycle; rx_valid SHALL be high from the next cycle if the FIFO was empty.
REQ-023 Stop bit = 0 SHALL pulse frame_error; otherwise a parity failure SHALL pulse parity_error; no push in either case.
REQ-024 Timeout counter SHALL clear in IDLE and on every falling edge, increment on each synchronized peripheral_clock rising edge, and saturate at OVER_TIME.
REQ-025 Counter reaching OVER_TIME outside IDLE SHALL pulse timeout_error once, discard the partial frame and return to IDLE; timeout wins over a simultaneous edge.
REQ-026 Each frame SHALL produce at most one error pulse.
REQ-027 FIFO SHALL be first-word fall-through: rx_data = head; rx_valid = (fifo_count != 0); pop on rx_valid & rx_ready.
REQ-028 Push and pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full.
REQ-029 Push while full without pop SHALL drop the byte and pulse overflow; FIFO contents SHALL be unchanged.
REQ-030 Pop while empty SHALL have no effect; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 inhibit_clock SHALL be registered and SHALL assert only in IDLE when fifo_count >= FIFO_DEPTH-1; it SHALL deassert when fifo_count < FIFO_DEPTH-1.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, an empty FIFO, fifo_count 0, rx_data 8'h00, rx_valid 0, inhibit_clock 0, all pulses 0 and all counters 0.
REQ-033 Reset mid-frame SHALL discard the frame with no error pulse; reception SHALL restart on the next start bit.

Structure
REQ-034 Package ps2_pkg SHALL hold the state enum ps2_rx_state_t and a function computing odd parity over 9 bits.
REQ-035 FIFO storage and pointers SHALL be the sub-module ps2_sync_fifo, parametrised by width and depth.

Verification
REQ-036 Send frame 0x1C with parity 0 and stop 1 -> one push; rx_data 8'h1C; rx_valid high until rx_ready.
REQ-037 Send 0x1C with parity 1 -> parity_error pulses once and fifo_count stays 0; same frame with PARITY_EN=0 -> accepted.
REQ-038 Stop clocking after 4 data bits, OVER_TIME=10 -> timeout_error after 10 ticks; state IDLE; next good frame received.
REQ-039 DEPTH=4: send 5 frames with no reads -> inhibit_clock after the 3rd push; 5th byte produces overflow; reads return bytes 1-4 in order.
REQ-040 Inject 2-cycle clock glitches with FILTER_LEN=4 -> no bit shifts; assert reset_n low mid-frame -> FIFO empty and no error pulse.
